haar_feature_fetch: RTL and testbench
=====================================

// Module: haar_feature_fetch
// PURPOSE
// - Sequencer directly upstream of the four Haar ROMs (rom_single_port_0..3). It drives their shared address and rden.
// - Captures the 4x16-bit lane outputs and packs WORDS_PER_FEATURE consecutive addresses into one feature record.
// - Hands each record to the classifier stage over a valid/ready handshake. Assembly and output registers are double-buffered.
// PARAMETERS
// - ADDR_W             13  ROM address width (8192 entries per lane ROM)
// - WORDS_PER_FEATURE  4   consecutive addresses per feature record (>=1)
// - READ_LATENCY       1   cycles from rden/address to valid q_* (1 or 2)
// - CNT_W              12  width of feature count and feature index
// PORTS
// - clk            in   1                        system clock
// - reset_n        in   1                        asynchronous active-low reset
// - start          in   1                        begin a fetch run (sampled in IDLE only)
// - base_addr      in   ADDR_W                   first ROM address of the run
// - feature_count  in   CNT_W                    number of features to fetch
// - busy           out  1                        run in progress
// - done           out  1                        1-cycle pulse, run complete
// - rom_addr       out  ADDR_W                   shared address to the 4 lane ROMs
// - rom_rden       out  1                        shared read enable to the 4 lane ROMs
// - q_0..q_3       in   16 each                  lane ROM read data
// - feat_valid     out  1                        feat_data holds a record
// - feat_ready     in   1                        consumer accepts the record
// - feat_data      out  WORDS_PER_FEATURE*64     word k at [k*64 +: 64] = {q_3,q_2,q_1,q_0}
// - feat_index     out  CNT_W                    0-based index of the record in the run
// - feat_last      out  1                        record is index feature_count-1
// BEHAVIOUR
// - Reset (async, any time, mid-run included): state=IDLE. busy, done, rom_rden, feat_valid, feat_last = 0.
//   rom_addr, feat_data, feat_index = 0. In-flight reads are discarded.
// - FSM states: IDLE, ISSUE, WAIT, FINISH.
//   - IDLE: start=1 latches base_addr and feature_count; busy=1 next cycle. count=0 goes to FINISH, otherwise to ISSUE.
//   - ISSUE: rom_rden=1 for WORDS_PER_FEATURE consecutive cycles. rom_addr = next address, incremented by 1 each cycle.
//     Address arithmetic is modulo 2^ADDR_W (wraps to 0, no error).
//   - WAIT: rom_rden=0. rom_addr holds its value. Waits until the assembly buffer is empty.
//     - More features remain: go to ISSUE.
//     - All issued and the last record handshaken (feat_valid&feat_ready): go to FINISH.
//   - FINISH: done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
// - start is ignored while busy=1.
// - Capture: data for an address issued in cycle t is sampled at the end of cycle t+READ_LATENCY into word slot k (k = issue order).
// - Assembly to output transfer: happens on the edge after the assembly buffer fills, if feat_valid=0 or (feat_valid&feat_ready).
//   Otherwise the buffer holds its contents and no new issue starts.
// - Latency: start high in cycle T gives rom_rden in T+1..T+WPF. First feat_valid in T+WPF+READ_LATENCY+2 (defaults: T+7).
// - Throughput unstalled: one record per WPF+READ_LATENCY+2 cycles. A new ISSUE never begins while the assembly buffer is full.
// - Handshake: while feat_valid=1 and feat_ready=0, feat_data, feat_index and feat_last hold stable.
//   feat_valid drops the cycle after acceptance unless a new record transfers on the same edge.
// - feature_count=0: no rom_rden, no feat_valid; done pulses in T+2.
// - q_* is ignored whenever no read is in flight.
// STRUCTURE
// - haar_pkg: WORD_W=16, ROM_LANES=4, LANE_W=64, FSM state enum, lane-packing function.
// - Sub-module haar_feature_assembler: slot counter, capture shift/valid pipeline of depth READ_LATENCY, full flag, transfer strobe.
// - Top level holds the FSM, address counter, feature counters and output register.
// TESTING
// - Reset, base=0, count=1, ready=1, q_n=addr*4+n: rden T+1..T+4, feat_valid T+7, word0={0003,0002,0001,0000}, last=1, done T+9.
// - count=3, ready=1: indices 0,1,2 in order, feat_last only on index 2, exactly 12 rden cycles, one done pulse.
// - count=4, ready held 0 for 20 cycles after first valid: record 0 held stable, only record 1 assembled.
//   Issue stalls (8 rden cycles max). Release gives back-to-back records.
// - base=8190, count=1: rom_addr sequence 8190, 8191, 0, 1; data packed in that order.
// - count=0: done pulse at T+2, no rden, no feat_valid. Also: start while busy is ignored; run length is unchanged.
// - reset_n low mid-ISSUE and mid-stall: all outputs 0 immediately. Next start after release runs cleanly from its new base.
//   Also repeat the first test with READ_LATENCY=2: first valid at T+8.

Source files
------------

// File: rtl/haar_pkg.sv
// Shared widths, FSM encoding and lane packing for the Haar feature fetch path.
package haar_pkg;
  localparam int WORD_W    = 16;
  localparam int ROM_LANES = 4;
  localparam int LANE_W    = WORD_W * ROM_LANES;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } fetch_state_e;

  function automatic logic [LANE_W-1:0] pack_lanes(
    input logic [WORD_W-1:0] q0,
    input logic [WORD_W-1:0] q1,
    input logic [WORD_W-1:0] q2,
    input logic [WORD_W-1:0] q3
  );
    return {q3, q2, q1, q0};
  endfunction
endpackage

// File: rtl/haar_feature_assembler.sv
// Collects returning lane words into one feature record and signals when the
// record can move into the output register.
module haar_feature_assembler
  import haar_pkg::*;
#(
  parameter int WPF          = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rden_i,
  input  logic [WORD_W-1:0]     q0_i,
  input  logic [WORD_W-1:0]     q1_i,
  input  logic [WORD_W-1:0]     q2_i,
  input  logic [WORD_W-1:0]     q3_i,
  input  logic                  out_valid_i,
  input  logic                  out_ready_i,
  output logic                  xfer_o,
  output logic                  empty_o,
  output logic [WPF*LANE_W-1:0] data_o
);
  localparam int SLOT_W = (WPF > 1) ? $clog2(WPF) : 1;

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    full_q, full_d;
  logic [WPF*LANE_W-1:0]   data_q, data_d;
  logic                    capture_s;

  assign capture_s = vld_q[READ_LATENCY-1];
  assign xfer_o    = full_q & (~out_valid_i | out_ready_i);
  // Empty only once no word is pending in the read pipeline or the slots.
  assign empty_o   = ~full_q & (slot_q == '0) & (vld_q == '0);
  assign data_o    = data_q;

  // Next state of the read-return pipeline, slot pointer and full flag.
  always_comb begin
    vld_d  = READ_LATENCY'({vld_q, rden_i});
    slot_d = slot_q;
    data_d = data_q;
    full_d = full_q & ~xfer_o;
    if (capture_s) begin
      data_d[slot_q*LANE_W +: LANE_W] = pack_lanes(q0_i, q1_i, q2_i, q3_i);
      if (slot_q == SLOT_W'(WPF-1)) begin
        slot_d = '0;
        full_d = 1'b1;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end else begin
      slot_d = slot_q;
    end
  end

  // Assembly state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      slot_q <= '0;
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      slot_q <= slot_d;
      full_q <= full_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/haar_feature_fetch.sv
// Sequences reads from the four Haar lane ROMs and hands packed feature
// records downstream over valid/ready.
module haar_feature_fetch
  import haar_pkg::*;
#(
  parameter int ADDR_W            = 13,
  parameter int WORDS_PER_FEATURE = 4,
  parameter int READ_LATENCY      = 1,
  parameter int CNT_W             = 12
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   base_addr,
  input  logic [CNT_W-1:0]                    feature_count,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_W-1:0]                   rom_addr,
  output logic                                rom_rden,
  input  logic [WORD_W-1:0]                   q_0,
  input  logic [WORD_W-1:0]                   q_1,
  input  logic [WORD_W-1:0]                   q_2,
  input  logic [WORD_W-1:0]                   q_3,
  output logic                                feat_valid,
  input  logic                                feat_ready,
  output logic [WORDS_PER_FEATURE*LANE_W-1:0] feat_data,
  output logic [CNT_W-1:0]                    feat_index,
  output logic                                feat_last
);
  localparam int WSEL_W = (WORDS_PER_FEATURE > 1) ? $clog2(WORDS_PER_FEATURE) : 1;

  fetch_state_e                        state_q;
  logic                                busy_q, done_q, rden_q;
  logic [ADDR_W-1:0]                   addr_q;
  logic [CNT_W-1:0]                    count_q, issued_q, out_idx_q;
  logic [WSEL_W-1:0]                   word_q;
  logic                                feat_valid_q, feat_last_q;
  logic [WORDS_PER_FEATURE*LANE_W-1:0] feat_data_q, asm_data_s;
  logic [CNT_W-1:0]                    feat_index_q;
  logic                                xfer_s, asm_empty_s, last_accept_s, run_start_s;

  assign run_start_s   = (state_q == ST_IDLE) & ~busy_q & start;
  assign last_accept_s = feat_valid_q & feat_ready & feat_last_q;

  haar_feature_assembler #(
    .WPF          (WORDS_PER_FEATURE),
    .READ_LATENCY (READ_LATENCY)
  ) u_asm (
    .clk         (clk),
    .reset_n     (reset_n),
    .rden_i      (rden_q),
    .q0_i        (q_0),
    .q1_i        (q_1),
    .q2_i        (q_2),
    .q3_i        (q_3),
    .out_valid_i (feat_valid_q),
    .out_ready_i (feat_ready),
    .xfer_o      (xfer_s),
    .empty_o     (asm_empty_s),
    .data_o      (asm_data_s)
  );

  // Run sequencer: address generation, issue bursts and completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rden_q   <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      word_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (run_start_s) begin
            busy_q   <= 1'b1;
            count_q  <= feature_count;
            issued_q <= '0;
            word_q   <= '0;
            if (feature_count == '0) begin
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_ISSUE;
              rden_q  <= 1'b1;
              addr_q  <= base_addr;
            end
          end
        end
        ST_ISSUE: begin
          if (word_q == WSEL_W'(WORDS_PER_FEATURE-1)) begin
            rden_q   <= 1'b0;
            issued_q <= issued_q + CNT_W'(1);
            state_q  <= ST_WAIT;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            word_q <= word_q + WSEL_W'(1);
          end
        end
        ST_WAIT: begin
          if (asm_empty_s) begin
            if (issued_q != count_q) begin
              state_q <= ST_ISSUE;
              rden_q  <= 1'b1;
              addr_q  <= addr_q + ADDR_W'(1);
              word_q  <= '0;
            end else if (last_accept_s) begin
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          rden_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output record register and per-run record index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      feat_valid_q <= 1'b0;
      feat_data_q  <= '0;
      feat_index_q <= '0;
      feat_last_q  <= 1'b0;
      out_idx_q    <= '0;
    end else if (run_start_s) begin
      out_idx_q <= '0;
    end else if (xfer_s) begin
      feat_valid_q <= 1'b1;
      feat_data_q  <= asm_data_s;
      feat_index_q <= out_idx_q;
      feat_last_q  <= (out_idx_q == count_q - CNT_W'(1));
      out_idx_q    <= out_idx_q + CNT_W'(1);
    end else if (feat_ready) begin
      feat_valid_q <= 1'b0;
    end else begin
      feat_valid_q <= feat_valid_q;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_addr   = addr_q;
  assign rom_rden   = rden_q;
  assign feat_valid = feat_valid_q;
  assign feat_data  = feat_data_q;
  assign feat_index = feat_index_q;
  assign feat_last  = feat_last_q;
endmodule

// File: tb/tb_haar_feature_fetch.sv
// Scoreboard bench for haar_feature_fetch: lane ROM model, expected address and
// record queues, and a monitor that checks every read and every handshake.
module tb_haar_feature_fetch;
  localparam int WPF = 4;
  localparam int AW  = 13;
  localparam int CW  = 12;
  localparam int DW  = WPF * 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] idx;
    logic          last;
  } rec_t;

  logic          clk = 1'b0;
  logic          reset_n, start, busy, done, rom_rden, feat_valid, feat_last;
  logic          feat_ready = 1'b1;
  logic [AW-1:0] base_addr, rom_addr;
  logic [CW-1:0] feature_count, feat_index;
  logic [15:0]   q_0, q_1, q_2, q_3;
  logic [DW-1:0] feat_data;
  logic          start2, busy2, done2, rom_rden2, feat_valid2, feat_last2;
  logic [AW-1:0] rom_addr2;
  logic [CW-1:0] feat_index2;
  logic [15:0]   q2_0, q2_1, q2_2, q2_3;
  logic [DW-1:0] feat_data2;

  int n_cmp = 0, n_bad = 0, cyc = 0, rmode = 0;
  int rden_total = 0, done_total = 0, acc_total = 0;
  int last_rden_cyc = -1, first_rden_cyc = -1, last_rise_cyc = -1, last_done_cyc = -1;
  rec_t          rec_q[$];
  logic [AW-1:0] addr_q[$];
  rec_t          mon_r;
  logic          prev_stall = 1'b0, prev_valid = 1'b0, prev_rden = 1'b0, prev_last;
  logic [DW-1:0] prev_data;
  logic [CW-1:0] prev_idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  haar_feature_fetch dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .feature_count(feature_count), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_rden(rom_rden), .q_0(q_0), .q_1(q_1), .q_2(q_2), .q_3(q_3),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
    .feat_index(feat_index), .feat_last(feat_last)
  );

  haar_feature_fetch #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .base_addr(13'd0),
    .feature_count(12'd1), .busy(busy2), .done(done2), .rom_addr(rom_addr2),
    .rom_rden(rom_rden2), .q_0(q2_0), .q_1(q2_1), .q_2(q2_2), .q_3(q2_3),
    .feat_valid(feat_valid2), .feat_ready(1'b1), .feat_data(feat_data2),
    .feat_index(feat_index2), .feat_last(feat_last2)
  );

  // Lane ROM models: q_n = addr*4+n after the read latency, junk otherwise.
  logic          r1_v = 1'b0, ra_v = 1'b0, rb_v = 1'b0;
  logic [AW-1:0] r1_a, ra_a, rb_a;
  logic [31:0]   junk;
  always @(posedge clk) begin
    r1_v <= rom_rden;  r1_a <= rom_addr;
    ra_v <= rom_rden2; ra_a <= rom_addr2;
    rb_v <= ra_v;      rb_a <= ra_a;
    junk <= $urandom;
  end
  assign q_0  = r1_v ? ({3'b000, r1_a} << 2)          : junk[15:0];
  assign q_1  = r1_v ? ({3'b000, r1_a} << 2) + 16'd1  : junk[31:16];
  assign q_2  = r1_v ? ({3'b000, r1_a} << 2) + 16'd2  : junk[15:0];
  assign q_3  = r1_v ? ({3'b000, r1_a} << 2) + 16'd3  : junk[31:16];
  assign q2_0 = rb_v ? ({3'b000, rb_a} << 2)          : junk[31:16];
  assign q2_1 = rb_v ? ({3'b000, rb_a} << 2) + 16'd1  : junk[15:0];
  assign q2_2 = rb_v ? ({3'b000, rb_a} << 2) + 16'd2  : junk[31:16];
  assign q2_3 = rb_v ? ({3'b000, rb_a} << 2) + 16'd3  : junk[15:0];

  // Consumer ready: 0 = always ready, 1 = random, other = held low.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       feat_ready = 1'b1;
      1:       feat_ready = 1'($urandom_range(0, 1));
      default: feat_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  function automatic logic [63:0] rom_word(input logic [AW-1:0] a);
    logic [15:0] b;
    b = {3'b000, a} << 2;
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  // Reference: a run reads count*WPF consecutive addresses mod 8192, WPF per record.
  task automatic expect_run(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      rec_t r;
      r.data = '0;
      for (int k = 0; k < WPF; k++) begin
        logic [AW-1:0] a;
        a = AW'((base + i * WPF + k) % 8192);
        addr_q.push_back(a);
        r.data[k*64 +: 64] = rom_word(a);
      end
      r.idx  = CW'(i);
      r.last = (i == count - 1);
      rec_q.push_back(r);
    end
  endtask

  // Monitor: compares every ROM read and accepted record, and checks hold-while-stalled.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      prev_rden  = 1'b0;
    end else begin
      if (rom_rden) begin
        rden_total++;
        last_rden_cyc = cyc;
        if (!prev_rden) first_rden_cyc = cyc;
        if (addr_q.size() == 0) fail_event("rden_unexpected");
        else check("rom_addr", DW'(rom_addr), DW'(addr_q.pop_front()));
      end
      if (done) begin
        done_total++;
        last_done_cyc = cyc;
      end
      if (feat_valid && !prev_valid) last_rise_cyc = cyc;
      if (prev_stall) begin
        check("hold_valid", DW'(feat_valid), DW'(1'b1));
        check("hold_data", feat_data, prev_data);
        check("hold_index", DW'(feat_index), DW'(prev_idx));
        check("hold_last", DW'(feat_last), DW'(prev_last));
      end
      if (feat_valid && feat_ready) begin
        acc_total++;
        if (rec_q.size() == 0) fail_event("record_unexpected");
        else begin
          mon_r = rec_q.pop_front();
          check("feat_data", feat_data, mon_r.data);
          check("feat_index", DW'(feat_index), DW'(mon_r.idx));
          check("feat_last", DW'(feat_last), DW'(mon_r.last));
        end
      end
      prev_stall = feat_valid && !feat_ready;
      prev_valid = feat_valid;
      prev_rden  = rom_rden;
      prev_data  = feat_data;
      prev_idx   = feat_index;
      prev_last  = feat_last;
    end
  end

  task automatic do_start(input int base, input int count, output int t);
    @(posedge clk); #1;
    base_addr     = AW'(base);
    feature_count = CW'(count);
    start         = 1'b1;
    t             = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int snap, input string name);
    int n = 0;
    while (done_total == snap && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_total == snap) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: actual=no done required=done pulse", name);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic end_checks(input string name, input int rden0, input int exp_rden, input int done0);
    check({name, "_rden_cycles"}, DW'(rden_total - rden0), DW'(exp_rden));
    check({name, "_done_pulses"}, DW'(done_total - done0), DW'(1));
    check({name, "_records_left"}, DW'(rec_q.size()), DW'(0));
    check({name, "_reads_left"}, DW'(addr_q.size()), DW'(0));
    check({name, "_busy_after"}, DW'(busy), DW'(0));
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctrl"}, DW'({busy, done, rom_rden, feat_valid, feat_last}), DW'(0));
    check({name, "_addr_idx"}, DW'({rom_addr, feat_index}), DW'(0));
    check({name, "_data"}, feat_data, '0);
  endtask

  task automatic run_full(input string name, input int base, input int count);
    int r0, d0, t;
    r0 = rden_total;
    d0 = done_total;
    expect_run(base, count);
    do_start(base, count, t);
    wait_done(d0, name);
    end_checks(name, r0, count * WPF, d0);
  endtask

  initial begin
    int t, r0, d0, a0, b, n;
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; base_addr = '0; feature_count = '0;
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset");
    check("reset_dut2", DW'({busy2, done2, rom_rden2, feat_valid2}), DW'(0));
    reset_n = 1'b1;

    // Single record from address 0: latency and packing.
    r0 = rden_total; d0 = done_total;
    expect_run(0, 1);
    do_start(0, 1, t);
    wait_done(d0, "t1");
    end_checks("t1", r0, 4, d0);
    check("t1_first_rden", DW'(first_rden_cyc), DW'(t + 1));
    check("t1_last_rden", DW'(last_rden_cyc), DW'(t + 4));
    check("t1_first_valid", DW'(last_rise_cyc), DW'(t + 7));
    check("t1_done_cycle", DW'(last_done_cyc), DW'(t + 9));

    // Three records with a start pulse during the run that must be ignored.
    r0 = rden_total; d0 = done_total;
    b = $urandom_range(0, 8191);
    expect_run(b, 3);
    do_start(b, 3, t);
    repeat (2) @(posedge clk);
    do_start(100, 5, n);
    wait_done(d0, "t2");
    end_checks("t2", r0, 12, d0);

    // Consumer stall: record 0 held, only record 1 assembled, then back-to-back release.
    rmode = 2;
    r0 = rden_total; d0 = done_total;
    b = $urandom_range(0, 8191);
    expect_run(b, 4);
    do_start(b, 4, t);
    n = 0;
    while (last_rise_cyc < t && n < 50) begin @(posedge clk); n++; end
    repeat (20) @(posedge clk);
    #1;
    check("t3_stall_rden", DW'(rden_total - r0), DW'(8));
    check("t3_stall_valid", DW'(feat_valid), DW'(1));
    @(posedge clk);
    rmode = 0;
    a0 = acc_total;
    repeat (2) @(posedge clk);
    check("t3_back_to_back", DW'(acc_total - a0), DW'(2));
    wait_done(d0, "t3");
    end_checks("t3", r0, 16, d0);

    // Address wrap at the top of the ROM.
    run_full("t4_wrap", 8190, 1);

    // Zero-length run.
    r0 = rden_total; d0 = done_total; a0 = acc_total;
    do_start(55, 0, t);
    wait_done(d0, "t5");
    check("t5_done_cycle", DW'(last_done_cyc), DW'(t + 2));
    check("t5_no_rden", DW'(rden_total - r0), DW'(0));
    check("t5_no_records", DW'(acc_total - a0), DW'(0));

    // Reset in the middle of an issue burst.
    r0 = rden_total;
    expect_run(300, 3);
    do_start(300, 3, t);
    n = 0;
    while (rden_total == r0 && n < 20) begin @(posedge clk); n++; end
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("rst_issue");
    rec_q.delete(); addr_q.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    run_full("t6_after", 4000, 2);

    // Reset while stalled with both buffers full.
    rmode = 2;
    expect_run(1234, 4);
    do_start(1234, 4, t);
    repeat (20) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("rst_stall");
    rec_q.delete(); addr_q.delete();
    rmode = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    run_full("t7_after", 8000, 3);

    // Randomized runs with a randomly throttled consumer.
    rmode = 1;
    for (int i = 0; i < 6; i++) begin
      run_full("rand", $urandom_range(0, 8191), $urandom_range(1, 5));
    end
    rmode = 0;

    // Two-cycle read latency: first valid one cycle later.
    @(posedge clk); #1;
    start2 = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = -1;
    for (int i = 0; i < 30 && n < 0; i++) begin
      @(negedge clk);
      if (feat_valid2) n = cyc;
    end
    check("rl2_first_valid", DW'(n), DW'(t + 8));
    check("rl2_word0", DW'(feat_data2[63:0]), DW'(64'h0003_0002_0001_0000));
    check("rl2_last", DW'({feat_last2, feat_index2}), DW'({1'b1, 12'd0}));
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
